// File: rtl/multicycle_issue_ctrl_pkg.sv
// Shared ARITHM definitions: opcode encodings and issue-controller state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package multicycle_issue_ctrl_pkg;

  localparam logic [3:0] OPC_MULTS = 4'd0;
  localparam logic [3:0] OPC_MULTU = 4'd1;
  localparam logic [3:0] OPC_DIVS  = 4'd2;
  localparam logic [3:0] OPC_DIVU  = 4'd3;
  localparam logic [3:0] OPC_MODS  = 4'd4;
  localparam logic [3:0] OPC_MODU  = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  function automatic logic is_mul_op(input logic [3:0] opc);
    return (opc == OPC_MULTS) || (opc == OPC_MULTU);
  endfunction

endpackage

// File: rtl/multicycle_issue_ctrl.sv
// Issues one EX instruction to the multi-cycle ARITHM unit and hands its result to writeback.
// Latency: alu_start 1 cycle after accept; wb_valid 1 cycle after alu_done.
// Backpressure: ex_ready only in IDLE; stall held until wb handshake; flush drains the ALU.
module multicycle_issue_ctrl
  import multicycle_issue_ctrl_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int OPC_W   = 4,
  parameter int DREG_W  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [OPC_W-1:0]  ex_opcode,
  input  logic [DATA_W-1:0] ex_a,
  input  logic [DATA_W-1:0] ex_b,
  input  logic [DREG_W-1:0] ex_dreg,
  input  logic              flush,
  output logic              stall,
  output logic              alu_start,
  output logic [OPC_W-1:0]  alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] alu_y,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DREG_W-1:0] wb_dreg,
  output logic [DATA_W-1:0] wb_data,
  output logic              err_timeout
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  state_t            state;
  logic [TMR_W-1:0]  timer;
  logic [DREG_W-1:0] dreg_q;
  logic              timer_exp;

  assign timer_exp = (timer == TMR_W'(TIMEOUT));
  assign ex_ready  = (state == ST_IDLE);
  // DRAIN releases the pipeline so the flushed stages can refill while the ALU finishes.
  assign stall     = (state != ST_DRAIN) && (ex_valid || (state != ST_IDLE));
  assign wb_dreg   = dreg_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      timer       <= '0;
      dreg_q      <= '0;
      alu_start   <= 1'b0;
      alu_opcode  <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      wb_valid    <= 1'b0;
      wb_data     <= '0;
      err_timeout <= 1'b0;
    end else begin
      alu_start <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (ex_valid && !flush) begin
            alu_opcode <= ex_opcode;
            alu_a      <= ex_a;
            alu_b      <= ex_b;
            dreg_q     <= ex_dreg;
            alu_start  <= 1'b1;
            timer      <= '0;
            state      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!timer_exp) timer <= timer + 1'b1;
          // A result already on the bus wins over timeout; r0 writes are suppressed.
          if (alu_done) begin
            if (flush || (dreg_q == '0)) begin
              state <= ST_IDLE;
            end else begin
              wb_data  <= alu_y;
              wb_valid <= 1'b1;
              state    <= ST_HOLD;
            end
          end else if (timer_exp) begin
            err_timeout <= 1'b1;
            state       <= ST_IDLE;
          end else if (flush) begin
            state <= ST_DRAIN;
          end
        end
        ST_HOLD: begin
          if (wb_ready || flush) begin
            wb_valid <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (!timer_exp) timer <= timer + 1'b1;
          if (alu_done) begin
            state <= ST_IDLE;
          end else if (timer_exp) begin
            err_timeout <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
